// File: rtl/multi_phase_pulse_gen_if.sv
// Control and phase-bus bundle for multi_phase_pulse_gen.
// The master drives run controls and observes the phase outputs.
interface multi_phase_pulse_gen_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned DIV_W = 8
);
    localparam int unsigned IDX_W = $clog2(2 * N);

    logic             en;
    logic [1:0]       mode;
    logic             dir;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     q;
    logic [IDX_W-1:0] phase_idx;
    logic             tick;
    logic             wrap;

    modport master (
        output en, mode, dir, div,
        input  q, phase_idx, tick, wrap
    );

    modport slave (
        input  en, mode, dir, div,
        output q, phase_idx, tick, wrap
    );
endinterface

// File: rtl/multi_phase_pulse_gen.sv
// N-phase pulse/sequence generator: prescaled step index decoded to one-hot ring,
// Johnson or ping-pong patterns, with tick and wrap strobes aligned to the new q.
module multi_phase_pulse_gen #(
    parameter int unsigned N     = 4,
    parameter int unsigned DIV_W = 8
) (
    input logic                    clk,
    input logic                    rs,
    multi_phase_pulse_gen_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(2 * N);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [N-1:0]     q_q, q_d;
    logic [1:0]       mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    function automatic logic [N-1:0] decode(input logic [1:0] m, input logic [IDX_W-1:0] k);
        int unsigned ki;
        int unsigned p;
        logic [N-1:0] r;
        ki = int'(k);
        p  = (ki < N) ? ki : 2 * N - 2 - ki;
        r  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            case (m)
                2'b00:   r[i] = (i == ki);
                // Johnson: fill from bit 0 upward, then drain from bit 0 upward
                2'b01:   r[i] = (ki < N) ? (i <= ki) : (i > ki - N);
                2'b10:   r[i] = (i == p);
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] seq_last(input logic [1:0] m);
        case (m)
            2'b00:   return IDX_W'(N - 1);
            2'b01:   return IDX_W'(2 * N - 1);
            2'b10:   return IDX_W'(2 * N - 3);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        cnt_d  = cnt_q;
        k_d    = k_q;
        q_d    = q_q;
        mode_d = mode_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (bus.mode != mode_q) begin
            // Mode change reloads the sequence regardless of en
            mode_d = bus.mode;
            cnt_d  = '0;
            k_d    = '0;
            q_d    = decode(bus.mode, '0);
        end else if (bus.en && (mode_q != 2'b11)) begin
            if (cnt_q >= bus.div) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (!bus.dir) begin
                    if (k_q == seq_last(mode_q)) begin
                        k_d    = '0;
                        wrap_d = 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    if (k_q == '0) begin
                        k_d    = seq_last(mode_q);
                        wrap_d = 1'b1;
                    end else begin
                        k_d = k_q - 1'b1;
                    end
                end
                q_d = decode(mode_q, k_d);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rs) begin
            cnt_q  <= '0;
            k_q    <= '0;
            q_q    <= N'(1);
            mode_q <= 2'b00;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            k_q    <= k_d;
            q_q    <= q_d;
            mode_q <= mode_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.phase_idx = k_q;
    assign bus.tick      = tick_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_multi_phase_pulse_gen.sv
// Bench for multi_phase_pulse_gen: constant vector table, directed corner sequences,
// then random stimulus checked against an arithmetic model of the sequence rules.
module tb_multi_phase_pulse_gen;
    localparam int N     = 4;
    localparam int DIV_W = 8;

    logic clk = 1'b0;
    logic rs  = 1'b0;
    always #5 clk = ~clk;

    multi_phase_pulse_gen_if #(.N(N), .DIV_W(DIV_W)) bus ();

    multi_phase_pulse_gen #(.N(N), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rs  (rs),
        .bus (bus)
    );

    typedef struct {
        logic       rs;
        logic       en;
        logic [1:0] mode;
        logic       dir;
        logic [7:0] div;
        logic [3:0] q;
        logic [2:0] idx;
        logic       tick;
        logic       wrap;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_cnt, m_k, m_mode, m_q, m_tick, m_wrap;

    function automatic int seq_len(input int m);
        case (m)
            0:       return N;
            1:       return 2 * N;
            2:       return 2 * N - 2;
            default: return 1;
        endcase
    endfunction

    function automatic int dec(input int m, input int k);
        int p;
        case (m)
            0: return 1 << k;
            1: begin
                if (k < N) return (1 << (k + 1)) - 1;
                return ((1 << N) - 1) & ~((1 << (k - N + 1)) - 1);
            end
            2: begin
                p = (k < N) ? k : 2 * N - 2 - k;
                return 1 << p;
            end
            default: return 0;
        endcase
    endfunction

    task automatic model_edge(input int r, input int e, input int md, input int d, input int dv);
        int len;
        m_tick = 0;
        m_wrap = 0;
        if (r == 0) begin
            m_cnt = 0; m_k = 0; m_mode = 0; m_q = 1;
        end else if (md != m_mode) begin
            m_mode = md; m_cnt = 0; m_k = 0; m_q = dec(md, 0);
        end else if (e != 0 && m_mode != 3) begin
            if (m_cnt >= dv) begin
                m_cnt  = 0;
                m_tick = 1;
                len    = seq_len(m_mode);
                if (d == 0) begin
                    m_wrap = (m_k == len - 1);
                    m_k    = (m_k + 1) % len;
                end else begin
                    m_wrap = (m_k == 0);
                    m_k    = (m_k + len - 1) % len;
                end
                m_q = dec(m_mode, m_k);
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic e, input logic [1:0] md, input logic d,
                         input logic [7:0] dv);
        rs       = r;
        bus.en   = e;
        bus.mode = md;
        bus.dir  = d;
        bus.div  = dv;
        @(posedge clk);
        model_edge(int'(r), int'(e), int'(md), int'(d), int'(dv));
        @(negedge clk);
        cmp("mdl_q",    int'(bus.q),         m_q);
        cmp("mdl_idx",  int'(bus.phase_idx), m_k);
        cmp("mdl_tick", int'(bus.tick),      m_tick);
        cmp("mdl_wrap", int'(bus.wrap),      m_wrap);
    endtask

    task automatic add(input logic r, input logic e, input logic [1:0] md, input logic d,
                       input logic [7:0] dv, input logic [3:0] eq, input logic [2:0] ei,
                       input logic et, input logic ew);
        tbl.push_back('{r, e, md, d, dv, eq, ei, et, ew});
    endtask

    initial begin
        logic [3:0] pp_q[6];
        logic [2:0] pp_k[6];
        m_cnt = 0; m_k = 0; m_mode = 0; m_q = 1; m_tick = 0; m_wrap = 0;
        bus.en = 1'b0; bus.mode = 2'b00; bus.dir = 1'b0; bus.div = '0;

        // Ring forward
        add(0, 0, 0, 0, 0, 4'h1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 4'h1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 4'h2, 1, 1, 0);
        add(1, 1, 0, 0, 0, 4'h4, 2, 1, 0);
        add(1, 1, 0, 0, 0, 4'h8, 3, 1, 0);
        add(1, 1, 0, 0, 0, 4'h1, 0, 1, 1);
        // Johnson
        add(0, 1, 1, 0, 0, 4'h1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 4'h1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 4'h3, 1, 1, 0);
        add(1, 1, 1, 0, 0, 4'h7, 2, 1, 0);
        add(1, 1, 1, 0, 0, 4'hf, 3, 1, 0);
        add(1, 1, 1, 0, 0, 4'he, 4, 1, 0);
        add(1, 1, 1, 0, 0, 4'hc, 5, 1, 0);
        add(1, 1, 1, 0, 0, 4'h8, 6, 1, 0);
        add(1, 1, 1, 0, 0, 4'h0, 7, 1, 0);
        add(1, 1, 1, 0, 0, 4'h1, 0, 1, 1);
        // Ping-pong with div=2
        add(0, 1, 2, 0, 2, 4'h1, 0, 0, 0);
        add(1, 1, 2, 0, 2, 4'h1, 0, 0, 0);
        add(1, 1, 2, 0, 2, 4'h1, 0, 0, 0);
        add(1, 1, 2, 0, 2, 4'h1, 0, 0, 0);
        pp_q = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};
        pp_k = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        for (int s = 0; s < 6; s++) begin
            if (s > 0) begin
                add(1, 1, 2, 0, 2, pp_q[s-1], pp_k[s-1], 0, 0);
                add(1, 1, 2, 0, 2, pp_q[s-1], pp_k[s-1], 0, 0);
            end
            add(1, 1, 2, 0, 2, pp_q[s], pp_k[s], 1, (s == 5));
        end
        // Ring reverse, then flip direction at 0100
        add(0, 1, 0, 1, 0, 4'h1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 4'h8, 3, 1, 1);
        add(1, 1, 0, 1, 0, 4'h4, 2, 1, 0);
        add(1, 1, 0, 1, 0, 4'h2, 1, 1, 0);
        add(1, 1, 0, 1, 0, 4'h1, 0, 1, 0);
        add(1, 1, 0, 1, 0, 4'h8, 3, 1, 1);
        add(1, 1, 0, 1, 0, 4'h4, 2, 1, 0);
        add(1, 1, 0, 0, 0, 4'h8, 3, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rs, tbl[i].en, tbl[i].mode, tbl[i].dir, tbl[i].div);
            cmp($sformatf("v%0d_q", i),    int'(bus.q),         int'(tbl[i].q));
            cmp($sformatf("v%0d_idx", i),  int'(bus.phase_idx), int'(tbl[i].idx));
            cmp($sformatf("v%0d_tick", i), int'(bus.tick),      int'(tbl[i].tick));
            cmp($sformatf("v%0d_wrap", i), int'(bus.wrap),      int'(tbl[i].wrap));
        end

        // Hold with en=0, reload on mode change with en=0, then off mode
        apply(0, 1, 0, 0, 0);
        apply(1, 1, 0, 0, 0);
        apply(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, 0, 0);
            cmp("hold_q", int'(bus.q), 4);
            cmp("hold_tick", int'(bus.tick), 0);
        end
        apply(1, 0, 1, 0, 0);
        cmp("mchg_q", int'(bus.q), 1);
        cmp("mchg_idx", int'(bus.phase_idx), 0);
        cmp("mchg_tick", int'(bus.tick), 0);
        for (int i = 0; i < 10; i++) begin
            apply(1, 1, 3, 0, 0);
            cmp("off_q", int'(bus.q), 0);
            cmp("off_tick", int'(bus.tick), 0);
        end
        apply(1, 1, 0, 0, 0);
        cmp("leave_off_q", int'(bus.q), 1);

        // div lowered below the running count, then reset mid-run
        apply(0, 1, 0, 0, 9);
        for (int i = 0; i < 6; i++) apply(1, 1, 0, 0, 9);
        cmp("cnt6_tick", int'(bus.tick), 0);
        apply(1, 1, 0, 0, 3);
        cmp("divdrop_tick", int'(bus.tick), 1);
        cmp("divdrop_q", int'(bus.q), 2);
        apply(1, 1, 0, 0, 3);
        apply(0, 1, 0, 0, 3);
        cmp("rst_q", int'(bus.q), 1);
        cmp("rst_tick", int'(bus.tick), 0);
        cmp("rst_wrap", int'(bus.wrap), 0);

        // Random stimulus against the model
        begin
            logic       r_en, r_dir;
            logic [1:0] r_mode;
            logic [7:0] r_div;
            r_en = 1'b1; r_dir = 1'b0; r_mode = 2'b00; r_div = 8'd1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 29) == 0) r_mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 19) == 0) r_dir = ~r_dir;
                if ($urandom_range(0, 19) == 0) r_div = 8'($urandom_range(0, 5));
                r_en = ($urandom_range(0, 9) != 0);
                apply(($urandom_range(0, 199) != 0), r_en, r_mode, r_dir, r_div);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
